alu_op_sequencer: RTL and testbench
===================================

# alu_op_sequencer

Multi-cycle controller that drives the shared-bus datapath around the combinational ALU (32-bit A/B operands, 5-bit opcode, 64-bit result). It accepts one register-to-register ALU instruction at a time and emits the per-cycle bus-out, register-in, Y/Z latch and HI/LO strobes needed to execute it. It sits between instruction decode and the register file / Y / Z / HI / LO registers. It owns every bus-source select and every register load enable during an ALU instruction.

## Interface
- REG_ADDR_W, 4, width of register-file address fields (16 GPRs)
- clk  in  1  system clock, all state changes on rising edge
- clear_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- opcode  in  5  ALU opcode:
  - 0 AND, 1 OR, 2 NOT, 3 NEG, 4 ADD, 5 SUB, 6 MUL
  - 7 DIV, 8 SHR, 9 SHRA, 10 SHL, 11 ROR, 12 ROL
- rd, rs1, rs2  in  REG_ADDR_W each  destination and source register fields
- bus_gnt  in  1  bus grant; low freezes the sequence
- gpr_out_en  out  1  drive GPR[gpr_out_sel] onto bus
- gpr_out_sel  out  REG_ADDR_W  GPR source select
- y_in  out  1  load Y from bus
- alu_op  out  5  opcode presented to ALU
- z_in  out  1  load 64-bit Z from ALU result
- zlo_out, zhi_out  out  1 each  drive Z[31:0] / Z[63:32] onto bus
- gpr_in_en  out  1  load GPR[gpr_in_sel] from bus
- gpr_in_sel  out  REG_ADDR_W  GPR destination select
- lo_in, hi_in  out  1 each  load LO / HI from bus
- busy  out  1  high from the cycle after acceptance through DONE
- done  out  1  one-cycle completion pulse
- illegal  out  1  with done: opcode was 13–31, nothing executed

## Operation
- States: IDLE, S_Y, S_Z, S_WB, S_LO, S_HI, DONE.
- IDLE, start=1: latch opcode, rd, rs1, rs2. Inputs are ignored at all other times.
- IDLE, start=1, opcode >12: go to DONE with illegal=1.
- Unary ops (NOT, NEG): IDLE → S_Z; otherwise IDLE → S_Y.
- S_Y: gpr_out_en=1, gpr_out_sel=rs1, y_in=1. Next state S_Z.
- S_Z: gpr_out_en=1, alu_op=latched opcode, z_in=1.
  - gpr_out_sel=rs1 for unary ops, rs2 otherwise.
  - Next state: S_LO for MUL/DIV, else S_WB.
- S_WB: zlo_out=1, gpr_in_en=1, gpr_in_sel=rd. Next state DONE.
- S_LO: zlo_out=1, lo_in=1. Next state S_HI.
- S_HI: zhi_out=1, hi_in=1. Next state DONE. rd is unused for MUL/DIV.
- DONE: done=1. illegal=1 only if the opcode was illegal. Next state IDLE.
- alu_op=0 outside S_Z. All select outputs are 0 when their enable is low.
- At most one bus source (gpr_out_en, zlo_out, zhi_out) is high in any cycle.
- bus_gnt=0 in S_Y, S_Z, S_WB, S_LO or S_HI:
  - state holds and all strobes and enables are forced to 0.
  - Selects and alu_op keep their values.
  - Resume on the first cycle bus_gnt=1.
- bus_gnt has no effect in IDLE or DONE.
- All outputs are combinational decodes of the state register and the latched fields.

## Timing
- Reset (clear_n=0, any time, including mid-sequence): state=IDLE, latched fields=0.
  - All outputs 0: busy, done, illegal, all strobes, selects, alu_op.
  - No partial write completes.
- start accepted at edge E0; the first strobe cycle follows E0.
- Latency from acceptance to the done-pulse cycle, with bus_gnt held high:
  - Binary ops: 4 cycles (S_Y, S_Z, S_WB, DONE).
  - Unary ops: 3 cycles.
  - MUL/DIV: 5 cycles.
  - Illegal opcode: 1 cycle.
- Each low cycle of bus_gnt in an active state adds exactly one cycle.
- A new start can be accepted at the edge ending the IDLE cycle after DONE.
- start held high continuously gives back-to-back instructions separated by one IDLE cycle.
- busy=1 exactly in active states and DONE.

## Test plan
- ADD, rd=3, rs1=1, rs2=2, bus_gnt=1:
  - Cycle 1: gpr_out_sel=1 with y_in.
  - Cycle 2: gpr_out_sel=2, alu_op=4, z_in.
  - Cycle 3: zlo_out, gpr_in_sel=3, gpr_in_en.
  - Cycle 4: done. illegal=0.
- NEG, rd=5, rs1=7: y_in never asserts.
  - Cycle 1: gpr_out_sel=7, alu_op=3, z_in.
  - done in cycle 3.
- MUL, rs1=4, rs2=6: S_Y, S_Z (alu_op=6), then zlo_out+lo_in, then zhi_out+hi_in. gpr_in_en never asserts; done in cycle 5.
- opcode=5'd20: done=illegal=1 in cycle 1. No strobe ever asserts; busy returns low in cycle 2.
- SUB with bus_gnt=0 for 2 cycles during S_Z:
  - All strobes stay 0 while bus_gnt=0; gpr_out_sel stays rs2.
  - z_in pulses once after bus_gnt returns high; done in cycle 6.
- DIV, clear_n low during S_LO: all outputs go 0 immediately, hi_in never asserts. After release, the next start executes normally.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Multi-cycle bus/strobe sequencer for one register-to-register ALU instruction.
// Outputs are decoded from the state register and the fields latched at acceptance.
module alu_op_sequencer #(
    parameter int unsigned REG_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  clear_n,
    input  logic                  start,
    input  logic [4:0]            opcode,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    input  logic                  bus_gnt,
    output logic                  gpr_out_en,
    output logic [REG_ADDR_W-1:0] gpr_out_sel,
    output logic                  y_in,
    output logic [4:0]            alu_op,
    output logic                  z_in,
    output logic                  zlo_out,
    output logic                  zhi_out,
    output logic                  gpr_in_en,
    output logic [REG_ADDR_W-1:0] gpr_in_sel,
    output logic                  lo_in,
    output logic                  hi_in,
    output logic                  busy,
    output logic                  done,
    output logic                  illegal
);

    localparam int unsigned OP_W    = 5;
    localparam logic [OP_W-1:0] OP_NOT  = OP_W'(2);
    localparam logic [OP_W-1:0] OP_NEG  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_MUL  = OP_W'(6);
    localparam logic [OP_W-1:0] OP_DIV  = OP_W'(7);
    localparam logic [OP_W-1:0] OP_LAST = OP_W'(12);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        S_Y  = 3'd1,
        S_Z  = 3'd2,
        S_WB = 3'd3,
        S_LO = 3'd4,
        S_HI = 3'd5,
        DONE = 3'd6
    } state_t;

    state_t                state_q, state_d;
    logic [OP_W-1:0]       opcode_q;
    logic [REG_ADDR_W-1:0] rd_q, rs1_q, rs2_q;

    function automatic logic is_unary(input logic [OP_W-1:0] op);
        return (op == OP_NOT) || (op == OP_NEG);
    endfunction

    function automatic logic is_muldiv(input logic [OP_W-1:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    // State register and instruction fields captured on acceptance
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q  <= IDLE;
            opcode_q <= '0;
            rd_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start) begin
                opcode_q <= opcode;
                rd_q     <= rd;
                rs1_q    <= rs1;
                rs2_q    <= rs2;
            end
        end
    end

    // Next state and output decode; a low grant gates strobes but keeps selects
    always_comb begin
        state_d     = state_q;
        gpr_out_en  = 1'b0;
        gpr_out_sel = '0;
        y_in        = 1'b0;
        alu_op      = '0;
        z_in        = 1'b0;
        zlo_out     = 1'b0;
        zhi_out     = 1'b0;
        gpr_in_en   = 1'b0;
        gpr_in_sel  = '0;
        lo_in       = 1'b0;
        hi_in       = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        illegal     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (opcode > OP_LAST)      state_d = DONE;
                    else if (is_unary(opcode)) state_d = S_Z;
                    else                       state_d = S_Y;
                end
            end
            S_Y: begin
                busy        = 1'b1;
                gpr_out_sel = rs1_q;
                gpr_out_en  = bus_gnt;
                y_in        = bus_gnt;
                if (bus_gnt) state_d = S_Z;
            end
            S_Z: begin
                busy        = 1'b1;
                gpr_out_sel = is_unary(opcode_q) ? rs1_q : rs2_q;
                alu_op      = opcode_q;
                gpr_out_en  = bus_gnt;
                z_in        = bus_gnt;
                if (bus_gnt) state_d = is_muldiv(opcode_q) ? S_LO : S_WB;
            end
            S_WB: begin
                busy       = 1'b1;
                gpr_in_sel = rd_q;
                zlo_out    = bus_gnt;
                gpr_in_en  = bus_gnt;
                if (bus_gnt) state_d = DONE;
            end
            S_LO: begin
                busy    = 1'b1;
                zlo_out = bus_gnt;
                lo_in   = bus_gnt;
                if (bus_gnt) state_d = S_HI;
            end
            S_HI: begin
                busy    = 1'b1;
                zhi_out = bus_gnt;
                hi_in   = bus_gnt;
                if (bus_gnt) state_d = DONE;
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                illegal = (opcode_q > OP_LAST);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench: each accepted instruction expands into a list of expected
// bus steps; a step with grant low repeats with its strobes suppressed.
module tb_alu_op_sequencer;

    typedef struct packed {
        logic       gpr_out_en;
        logic [3:0] gpr_out_sel;
        logic       y_in;
        logic [4:0] alu_op;
        logic       z_in;
        logic       zlo_out;
        logic       zhi_out;
        logic       gpr_in_en;
        logic [3:0] gpr_in_sel;
        logic       lo_in;
        logic       hi_in;
        logic       busy;
        logic       done;
        logic       illegal;
    } outv_t;

    typedef struct packed {
        outv_t o;
        logic  gated;
    } step_t;

    logic       clk, clear_n, start, bus_gnt;
    logic [4:0] opcode;
    logic [3:0] rd, rs1, rs2;
    logic       gpr_out_en, y_in, z_in, zlo_out, zhi_out, gpr_in_en;
    logic       lo_in, hi_in, busy, done, illegal;
    logic [3:0] gpr_out_sel, gpr_in_sel;
    logic [4:0] alu_op;
    outv_t      act;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    step_t q[$];

    alu_op_sequencer #(.REG_ADDR_W(4)) dut (
        .clk(clk), .clear_n(clear_n), .start(start), .opcode(opcode),
        .rd(rd), .rs1(rs1), .rs2(rs2), .bus_gnt(bus_gnt),
        .gpr_out_en(gpr_out_en), .gpr_out_sel(gpr_out_sel), .y_in(y_in),
        .alu_op(alu_op), .z_in(z_in), .zlo_out(zlo_out), .zhi_out(zhi_out),
        .gpr_in_en(gpr_in_en), .gpr_in_sel(gpr_in_sel), .lo_in(lo_in),
        .hi_in(hi_in), .busy(busy), .done(done), .illegal(illegal)
    );

    assign act = {gpr_out_en, gpr_out_sel, y_in, alu_op, z_in, zlo_out, zhi_out,
                  gpr_in_en, gpr_in_sel, lo_in, hi_in, busy, done, illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic outv_t strobes_off(input outv_t o);
        outv_t r = o;
        r.gpr_out_en = 1'b0; r.y_in = 1'b0; r.z_in = 1'b0; r.zlo_out = 1'b0;
        r.zhi_out = 1'b0; r.gpr_in_en = 1'b0; r.lo_in = 1'b0; r.hi_in = 1'b0;
        return r;
    endfunction

    task automatic push(input outv_t o, input logic gated);
        step_t s;
        s.o = o;
        s.gated = gated;
        q.push_back(s);
    endtask

    // Expand one accepted instruction into its expected cycle sequence
    task automatic expand(input logic [4:0] op, input logic [3:0] d, s1, s2);
        outv_t o;
        logic  unary, md;
        unary = (op == 5'd2) || (op == 5'd3);
        md    = (op == 5'd6) || (op == 5'd7);
        if (op > 5'd12) begin
            o = '0; o.busy = 1'b1; o.done = 1'b1; o.illegal = 1'b1;
            push(o, 1'b0);
            return;
        end
        if (!unary) begin
            o = '0; o.busy = 1'b1; o.gpr_out_en = 1'b1; o.gpr_out_sel = s1; o.y_in = 1'b1;
            push(o, 1'b1);
        end
        o = '0; o.busy = 1'b1; o.gpr_out_en = 1'b1; o.gpr_out_sel = unary ? s1 : s2;
        o.alu_op = op; o.z_in = 1'b1;
        push(o, 1'b1);
        if (md) begin
            o = '0; o.busy = 1'b1; o.zlo_out = 1'b1; o.lo_in = 1'b1;
            push(o, 1'b1);
            o = '0; o.busy = 1'b1; o.zhi_out = 1'b1; o.hi_in = 1'b1;
            push(o, 1'b1);
        end else begin
            o = '0; o.busy = 1'b1; o.zlo_out = 1'b1; o.gpr_in_en = 1'b1; o.gpr_in_sel = d;
            push(o, 1'b1);
        end
        o = '0; o.busy = 1'b1; o.done = 1'b1;
        push(o, 1'b0);
    endtask

    // One clock cycle: apply inputs, compare mid-cycle, advance the model
    task automatic step(input logic st, input logic [4:0] op,
                        input logic [3:0] d, s1, s2, input logic g);
        outv_t exp;
        start = st; opcode = op; rd = d; rs1 = s1; rs2 = s2; bus_gnt = g;
        @(negedge clk);
        if (q.size() == 0) exp = '0;
        else if (q[0].gated && !g) exp = strobes_off(q[0].o);
        else exp = q[0].o;
        check("outs", {8'h0, act}, {8'h0, exp});
        if (q.size() == 0) begin
            if (st) expand(op, d, s1, s2);
        end else if (!(q[0].gated && !g)) begin
            void'(q.pop_front());
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 4'd0, 4'd0, 4'd0, 1'b1);
    endtask

    initial begin
        clear_n = 1'b0; start = 1'b0; opcode = '0; rd = '0; rs1 = '0; rs2 = '0; bus_gnt = 1'b1;
        #1;
        check("reset", {8'h0, act}, 32'h0);
        @(posedge clk);
        #1;
        clear_n = 1'b1;
        idle(1);

        // ADD r3 = r1 + r2
        step(1'b1, 5'd4, 4'd3, 4'd1, 4'd2, 1'b1);
        idle(5);
        // NEG r5 = -r7
        step(1'b1, 5'd3, 4'd5, 4'd7, 4'd9, 1'b1);
        idle(4);
        // MUL r4 * r6
        step(1'b1, 5'd6, 4'd8, 4'd4, 4'd6, 1'b1);
        idle(6);
        // Illegal opcode
        step(1'b1, 5'd20, 4'd1, 4'd2, 4'd3, 1'b1);
        idle(2);
        // SUB with two stalled cycles in S_Z
        step(1'b1, 5'd5, 4'd10, 4'd11, 4'd12, 1'b1);
        step(1'b0, 5'd0, 4'd0, 4'd0, 4'd0, 1'b1);
        step(1'b0, 5'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        step(1'b0, 5'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        idle(5);
        // Back-to-back with start held high
        for (int i = 0; i < 10; i++) step(1'b1, 5'd1, 4'd2, 4'd3, 4'd4, 1'b1);
        idle(5);

        // DIV, reset asserted while in S_LO
        step(1'b1, 5'd7, 4'd1, 4'd13, 4'd14, 1'b1);
        step(1'b0, 5'd0, 4'd0, 4'd0, 4'd0, 1'b1);
        step(1'b0, 5'd0, 4'd0, 4'd0, 4'd0, 1'b1);
        check("div_in_lo", {31'h0, lo_in}, 32'h1);
        #2;
        clear_n = 1'b0;
        #1;
        check("rst_mid", {8'h0, act}, 32'h0);
        q.delete();
        @(posedge clk);
        #1;
        check("rst_hold", {8'h0, act}, 32'h0);
        clear_n = 1'b1;
        idle(2);
        step(1'b1, 5'd0, 4'd6, 4'd5, 4'd4, 1'b1);
        idle(5);

        // Randomized traffic, inputs toggling freely while busy
        for (int i = 0; i < 600; i++) begin
            logic [4:0] op;
            op = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                             : 5'($urandom_range(0, 12));
            step(1'($urandom_range(0, 1)), op, 4'($urandom), 4'($urandom), 4'($urandom),
                 ($urandom_range(0, 3) != 0));
        end
        idle(8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
